i2c_if: RTL and testbench

I2C_IF -- requirements
Module: i2c_if

---
 rtl/i2c_if.sv | 218 +++++++++++++++++++++
 tb/tb_i2c_if.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_if.sv
// I2C slave front end: synchronised bus sampling, address match, write/read byte streaming.
// Define I2C_IF_GENERAL_CALL_EN to also accept the general-call address (7'h00, write).
module i2c_if #(
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int I2C_DATA_WIDTH = 8,
    parameter logic [I2C_ADDR_WIDTH-1:0] I2C_DEVICE_ADDR = 7'h22
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      sda_o,
    output logic                      wr_valid,
    output logic [I2C_DATA_WIDTH-1:0] wr_data,
    output logic                      rd_req,
    input  logic [I2C_DATA_WIDTH-1:0] rd_data,
    output logic                      busy,
    output logic                      op,
    output logic                      done
);

    localparam int AW = I2C_ADDR_WIDTH;
    localparam int DW = I2C_DATA_WIDTH;
    localparam int CW = $clog2(DW + 1);
    localparam logic [CW-1:0] ADDR_LAST = CW'(AW);
    localparam logic [CW-1:0] DATA_LAST = CW'(DW - 1);
    localparam logic [CW-1:0] DATA_END  = CW'(DW);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } state_t;

    state_t state, state_nx;

    logic scl_m, scl_s, scl_p;
    logic sda_m, sda_s, sda_p;

    logic [CW-1:0] cnt, cnt_nx;
    logic [DW-1:0] sh, sh_nx;
    logic [DW-1:0] nxt;
    logic          ack, ack_nx;
    logic          sda_nx;
    logic          busy_nx, op_nx, done_nx;
    logic [DW-1:0] wr_data_nx;
    logic          wv_pend, wv_nx;
    logic          rd_req_nx, rd_dly;
    logic          rise, fall, start_c, stop_c;
    logic          addr_hit;

    assign rise    = scl_s & ~scl_p;
    assign fall    = ~scl_s & scl_p;
    assign start_c = scl_s & scl_p & sda_p & ~sda_s;
    assign stop_c  = scl_s & scl_p & ~sda_p & sda_s;
    assign nxt     = {sh[DW-2:0], sda_s};

    always_comb begin
        addr_hit = (nxt[AW:1] == I2C_DEVICE_ADDR);
`ifdef I2C_IF_GENERAL_CALL_EN
        if (nxt[AW:0] == '0) addr_hit = 1'b1;
`endif
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        sh_nx      = sh;
        ack_nx     = ack;
        sda_nx     = sda_o;
        busy_nx    = busy;
        op_nx      = op;
        wr_data_nx = wr_data;
        done_nx    = 1'b0;
        rd_req_nx  = 1'b0;
        wv_nx      = 1'b0;
        // read byte arrives two cycles after its request
        if (rd_dly) sh_nx = rd_data;
        if (start_c || stop_c) begin
            state_nx = start_c ? ADDR : IDLE;
            cnt_nx   = '0;
            ack_nx   = 1'b0;
            sda_nx   = 1'b1;
            if (busy) begin
                done_nx = 1'b1;
                busy_nx = 1'b0;
            end
        end else begin
            unique case (state)
                IDLE, IGNORE: sda_nx = 1'b1;
                ADDR: begin
                    if (rise) begin
                        sh_nx  = nxt;
                        cnt_nx = cnt + 1'b1;
                        if (cnt == ADDR_LAST) begin
                            cnt_nx = '0;
                            if (addr_hit) begin
                                state_nx = ADDR_ACK;
                                op_nx    = nxt[0];
                                busy_nx  = 1'b1;
                                ack_nx   = 1'b0;
                            end else begin
                                state_nx = IGNORE;
                            end
                        end
                    end
                end
                ADDR_ACK, WR_ACK: begin
                    if (fall) begin
                        if (!ack) begin
                            sda_nx = 1'b0;
                            ack_nx = 1'b1;
                        end else begin
                            sda_nx   = 1'b1;
                            ack_nx   = 1'b0;
                            state_nx = WR_DATA;
                            cnt_nx   = '0;
                        end
                    end else if (rise && ack && op && state == ADDR_ACK) begin
                        // ACK stays low until the first data fall drives the MSB
                        rd_req_nx = 1'b1;
                        state_nx  = RD_DATA;
                        cnt_nx    = '0;
                        ack_nx    = 1'b0;
                    end
                end
                WR_DATA: begin
                    if (rise) begin
                        sh_nx  = nxt;
                        cnt_nx = cnt + 1'b1;
                        if (cnt == DATA_LAST) begin
                            wr_data_nx = nxt;
                            wv_nx      = 1'b1;
                            state_nx   = WR_ACK;
                            ack_nx     = 1'b0;
                            cnt_nx     = '0;
                        end
                    end
                end
                RD_DATA: begin
                    if (rise) begin
                        cnt_nx = cnt + 1'b1;
                    end else if (fall) begin
                        if (cnt == DATA_END) begin
                            sda_nx   = 1'b1;
                            state_nx = RD_ACK;
                        end else begin
                            sda_nx = sh[DW-1];
                            sh_nx  = {sh[DW-2:0], 1'b0};
                        end
                    end
                end
                RD_ACK: begin
                    if (rise) begin
                        if (!sda_s) begin
                            rd_req_nx = 1'b1;
                            state_nx  = RD_DATA;
                            cnt_nx    = '0;
                        end else begin
                            state_nx = IGNORE;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_m    <= 1'b1;
            scl_s    <= 1'b1;
            scl_p    <= 1'b1;
            sda_m    <= 1'b1;
            sda_s    <= 1'b1;
            sda_p    <= 1'b1;
            state    <= IDLE;
            cnt      <= '0;
            sh       <= '0;
            ack      <= 1'b0;
            sda_o    <= 1'b1;
            busy     <= 1'b0;
            op       <= 1'b0;
            done     <= 1'b0;
            wr_data  <= '0;
            wv_pend  <= 1'b0;
            wr_valid <= 1'b0;
            rd_req   <= 1'b0;
            rd_dly   <= 1'b0;
        end else begin
            scl_m    <= scl_i;
            scl_s    <= scl_m;
            scl_p    <= scl_s;
            sda_m    <= sda_i;
            sda_s    <= sda_m;
            sda_p    <= sda_s;
            state    <= state_nx;
            cnt      <= cnt_nx;
            sh       <= sh_nx;
            ack      <= ack_nx;
            sda_o    <= sda_nx;
            busy     <= busy_nx;
            op       <= op_nx;
            done     <= done_nx;
            wr_data  <= wr_data_nx;
            wv_pend  <= wv_nx;
            wr_valid <= wv_pend;
            rd_req   <= rd_req_nx;
            rd_dly   <= rd_req;
        end
    end

endmodule

// File: tb/tb_i2c_if.sv
// Bench for i2c_if: bit-banged I2C master, transaction-level model and per-cycle monitor.
module tb_i2c_if;

    localparam int H = 5;
`ifdef I2C_IF_GENERAL_CALL_EN
    localparam bit GC = 1'b1;
`else
    localparam bit GC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] rd_data = 8'h00;
    logic       sda_o, wr_valid, rd_req, busy, op, done;
    logic [7:0] wr_data;
    logic       sda_bus;

    assign sda_bus = sda_m & sda_o;

    always #5 clk = ~clk;

    i2c_if dut (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl_m),
        .sda_i    (sda_bus),
        .sda_o    (sda_o),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .rd_req   (rd_req),
        .rd_data  (rd_data),
        .busy     (busy),
        .op       (op),
        .done     (done)
    );

    int checks = 0;
    int passes = 0;
    int nwr = 0, nrd = 0, ndone = 0;
    bit quiet = 1'b1;
    logic [7:0] exp_wq[$];
    logic [7:0] rd_q[$];
    logic [7:0] pay[$];
    logic [7:0] last_rd;

    task automatic check(input bit ok, input string nm,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic bit match(input logic [6:0] a, input bit rw);
        return (a == 7'h22) || (GC && a == 7'h00 && !rw);
    endfunction

    // monitor and read-data responder
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (quiet)
                check(sda_o === 1'b1 && busy === 1'b0, "quiet",
                      {sda_o, busy}, 2'b10);
            if (wr_valid) begin
                nwr++;
                check(exp_wq.size() != 0, "wr_extra", nwr, 0);
                if (exp_wq.size() != 0) begin
                    e = exp_wq.pop_front();
                    check(wr_data == e, "wr_data", wr_data, e);
                end
                check(op == 1'b0 && busy == 1'b1, "wr_op_busy", {op, busy}, 2'b01);
            end
            if (rd_req) begin
                nrd++;
                check(op == 1'b1, "rd_op", op, 1);
                check(rd_q.size() != 0, "rd_extra", nrd, 0);
                if (rd_q.size() != 0) rd_data = rd_q.pop_front();
            end
            if (done) ndone++;
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clock_bit(input bit b, output bit r);
        sda_m = b;
        wait_n(H);
        scl_m = 1'b1;
        wait_n(H);
        r = sda_bus;
        scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wait_n(H);
        scl_m = 1'b1;
        wait_n(H);
        sda_m = 1'b0;
        wait_n(H);
        scl_m = 1'b0;
        wait_n(H);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wait_n(H);
        scl_m = 1'b1;
        wait_n(H);
        sda_m = 1'b1;
        wait_n(H);
    endtask

    task automatic write_byte(input logic [7:0] v, output bit ackd);
        bit r;
        for (int i = 7; i >= 0; i--) clock_bit(v[i], r);
        clock_bit(1'b1, r);
        ackd = !r;
    endtask

    task automatic read_byte(input bit ackit, output logic [7:0] b);
        bit r;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, r);
            b[i] = r;
        end
        clock_bit(!ackit, r);
    endtask

    task automatic xfer(input logic [6:0] a, input bit rw,
                        input bit skip_start, input bit end_rs);
        bit m, ackd;
        logic [7:0] b;
        int n;
        n = pay.size();
        m = match(a, rw);
        nwr = 0;
        nrd = 0;
        ndone = 0;
        quiet = !m;
        if (m && !rw) exp_wq = pay;
        if (m && rw) rd_q = pay;
        if (!skip_start) i2c_start();
        write_byte({a, rw}, ackd);
        check(ackd == m, "addr_ack", ackd, m);
        for (int k = 0; k < n; k++) begin
            if (m && rw) begin
                read_byte(k < n - 1, b);
                check(b == pay[k], "rd_byte", b, pay[k]);
                last_rd = b;
            end else begin
                write_byte(pay[k], ackd);
                check(ackd == m, "data_ack", ackd, m);
            end
        end
        if (end_rs) i2c_start();
        else i2c_stop();
        wait_n(2);
        quiet = 1'b1;
        check(nwr == ((m && !rw) ? n : 0), "n_wr", nwr, (m && !rw) ? n : 0);
        check(nrd == ((m && rw) ? n : 0), "n_rd", nrd, (m && rw) ? n : 0);
        check(ndone == int'(m), "n_done", ndone, m);
        check(busy == 1'b0, "busy_end", busy, 0);
        check(exp_wq.size() == 0 && rd_q.size() == 0, "leftover",
              exp_wq.size() + rd_q.size(), 0);
    endtask

    initial begin
        bit r, prev_rs;
        wait_n(4);
        check(sda_o == 1'b1, "rst_sda", sda_o, 1);
        check(wr_valid == 1'b0, "rst_wr_valid", wr_valid, 0);
        check(rd_req == 1'b0, "rst_rd_req", rd_req, 0);
        check(done == 1'b0, "rst_done", done, 0);
        check(busy == 1'b0, "rst_busy", busy, 0);
        check(op == 1'b0, "rst_op", op, 0);
        check(wr_data == 8'h00, "rst_wr_data", wr_data, 0);
        rst = 1'b1;
        wait_n(4);

        pay.delete();
        for (int i = 0; i < 32; i++) pay.push_back(8'(i));
        xfer(7'h22, 1'b0, 1'b0, 1'b0);
        check(wr_data == 8'h1F, "wr_last", wr_data, 8'h1F);

        pay.delete();
        for (int i = 100; i < 132; i++) pay.push_back(8'(i));
        xfer(7'h22, 1'b1, 1'b0, 1'b0);
        check(last_rd == 8'd131, "rd_last", last_rd, 131);
        check(op == 1'b1, "rd_op_hold", op, 1);

        for (int i = 0; i < 64; i++) begin
            pay = '{8'(64 + i)};
            xfer(7'h22, 1'b0, 1'b0, 1'b0);
            pay = '{8'(63 - i)};
            xfer(7'h22, 1'b1, 1'b0, 1'b0);
        end

        pay = '{8'h12, 8'h34};
        xfer(7'h23, 1'b0, 1'b0, 1'b0);
        xfer(7'h00, 1'b0, 1'b0, 1'b0);

        // reset in the 4th data bit of a write
        quiet = 1'b0;
        i2c_start();
        write_byte(8'h44, r);
        check(r == 1'b1, "pre_rst_ack", r, 1);
        clock_bit(1'b0, r);
        clock_bit(1'b0, r);
        clock_bit(1'b1, r);
        sda_m = 1'b1;
        wait_n(H);
        scl_m = 1'b1;
        wait_n(2);
        quiet = 1'b1;
        rst = 1'b0;
        #1;
        check(sda_o == 1'b1, "mid_rst_sda", sda_o, 1);
        wait_n(4);
        rst = 1'b1;
        wait_n(2);
        scl_m = 1'b0;
        wait_n(H);
        pay = '{8'hA5};
        xfer(7'h22, 1'b0, 1'b0, 1'b0);
        check(wr_data == 8'hA5, "post_rst_wr", wr_data, 8'hA5);

        prev_rs = 1'b0;
        for (int t = 0; t < 16; t++) begin
            logic [6:0] a;
            bit rw, rs;
            int n;
            a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'h22;
            rw = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 4);
            pay.delete();
            repeat (n) pay.push_back(8'($urandom));
            xfer(a, rw, prev_rs, rs);
            prev_rs = rs;
        end
        if (prev_rs) i2c_stop();
        wait_n(4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
